// File: rtl/actuate_motor_axil_regs.sv
// AXI4-Lite register block (CTRL/PERIOD/DUTY/SCRATCH) with a PWM/direction generator.
// Define ACTUATE_MOTOR_PWM_EN to build the PWM counter; otherwise pwm_out is tied low.
module actuate_motor_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int PWM_WIDTH          = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              pwm_out,
    output logic                              dir_out
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    logic [DW-1:0] regs [4];

    logic          aw_held, w_held;
    logic [1:0]    aw_sel_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic          aw_held_nxt, w_held_nxt, bvalid_nxt, rvalid_nxt;
    logic [1:0]    wr_sel;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // A beat arriving this cycle is used directly so the commit lands in the last handshake cycle.
    assign commit  = (aw_held | aw_hs) & (w_held | w_hs);
    assign wr_sel  = aw_held ? aw_sel_q : S_AXI_AWADDR[3:2];
    assign wr_data = w_held ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;

    assign aw_held_nxt = (aw_held | aw_hs) & ~commit;
    assign w_held_nxt  = (w_held | w_hs) & ~commit;
    assign bvalid_nxt  = commit | (S_AXI_BVALID & ~S_AXI_BREADY);
    assign rvalid_nxt  = ar_hs | (S_AXI_RVALID & ~S_AXI_RREADY);

    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_sel_q      <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
        end else begin
            aw_held       <= aw_held_nxt;
            w_held        <= w_held_nxt;
            S_AXI_AWREADY <= ~aw_held_nxt & ~bvalid_nxt;
            S_AXI_WREADY  <= ~w_held_nxt & ~bvalid_nxt;
            S_AXI_BVALID  <= bvalid_nxt;
            if (aw_hs) begin
                aw_sel_q <= S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int r = 0; r < 4; r++) begin
                regs[r] <= '0;
            end
        end else if (commit) begin
            for (int b = 0; b < SW; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_sel][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read data is captured from the pre-commit register contents.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_ARREADY <= ~rvalid_nxt;
            S_AXI_RVALID  <= rvalid_nxt;
            if (ar_hs) begin
                S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
            end
        end
    end

    assign dir_out = regs[0][1];

`ifdef ACTUATE_MOTOR_PWM_EN
    logic [PWM_WIDTH-1:0] pwm_cnt, period_sh, duty_sh;

    // Shadows only reload at wrap (or while idle) so a period never sees a half-updated setting.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pwm_cnt   <= '0;
            period_sh <= '0;
            duty_sh   <= '0;
        end else if (!regs[0][0] || period_sh == '0 ||
                     pwm_cnt == period_sh - PWM_WIDTH'(1)) begin
            pwm_cnt   <= '0;
            period_sh <= regs[1][PWM_WIDTH-1:0];
            duty_sh   <= regs[2][PWM_WIDTH-1:0];
        end else begin
            pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
        end
    end

    assign pwm_out = regs[0][0] & (period_sh != '0) & (pwm_cnt < duty_sh);
`else
    assign pwm_out = 1'b0;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                             (PWM_WIDTH > 0)};

endmodule
